// File: rtl/calc_pkg.sv
// Shared definitions for the sequential calculator: opcodes, FSM encoding
// and the default operand width.
package calc_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide,
// one bit per clock, WIDTH iterations after a load.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_mag_a,
  input  logic [WIDTH-1:0]   i_mag_b,
  output logic [2*WIDTH-1:0] o_prod,
  output logic [WIDTH-1:0]   o_quot,
  output logic [WIDTH-1:0]   o_rem,
  output logic               o_fin
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);

  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvsr;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;

  // Counter parks at CNT_END when idle so no iteration runs on stale data.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= CNT_END;
    else if (i_load)
      r_cnt <= '0;
    else if (r_cnt != CNT_END)
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvsr};

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_div    <= i_div;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_mag_a};
      r_mplier <= i_mag_b;
      r_rem    <= '0;
      r_quo    <= i_mag_a;
      r_dvsr   <= i_mag_b;
    end else if (r_cnt != CNT_END) begin
      if (!r_div) begin
        if (r_mplier[0])
          r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else if (!w_trial[WIDTH]) begin
        r_rem <= w_trial[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign o_prod = r_acc;
  assign o_quot = r_quo;
  assign o_rem  = r_rem;
  assign o_fin  = (r_cnt == CNT_END);

endmodule

// File: rtl/seq_calculator.sv
// Multi-cycle add/sub/mul/div unit with start/busy/done handshake. Sign
// handling and status flags live here; the magnitude loop is in calc_iter_unit.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic               signed_operation,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               valid,
  output logic               overflow,
  output logic               divide_by_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] f_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t r_state, w_next;

  logic               w_accept, w_dbz, w_load, w_fin;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic signed [WIDTH:0] w_ext_a, w_ext_b, w_sum;
  logic [2*WIDTH-1:0] w_as_res;
  logic               w_as_ovf;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH-1:0]   w_quot_mag, w_rem_mag, w_quot, w_rem;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_ovf;

  logic               r_div, r_sgn, r_neg_q, r_neg_r, r_min_ovf;
  logic [2*WIDTH-1:0] r_res_p0;
  logic               r_vld_p0, r_ovf_p0, r_dbz_p0;
  logic [2*WIDTH-1:0] r_result;
  logic               r_valid, r_overflow, r_dbz, r_done;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_dbz    = (mode == MODE_DIV) && (operand_b == '0);
  assign w_load   = w_accept && mode[1] && !w_dbz;

  assign w_neg_a = signed_operation & operand_a[WIDTH-1];
  assign w_neg_b = signed_operation & operand_b[WIDTH-1];
  assign w_mag_a = f_neg_w(operand_a, w_neg_a);
  assign w_mag_b = f_neg_w(operand_b, w_neg_b);

  // Add/sub: exact (WIDTH+1)-bit result, extended according to signedness.
  assign w_ext_a  = signed_operation ? {operand_a[WIDTH-1], operand_a} : {1'b0, operand_a};
  assign w_ext_b  = signed_operation ? {operand_b[WIDTH-1], operand_b} : {1'b0, operand_b};
  assign w_sum    = (mode == MODE_SUB) ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);
  assign w_as_res = signed_operation ? {{(WIDTH-1){w_sum[WIDTH]}}, w_sum}
                                     : {{(WIDTH-1){1'b0}}, w_sum};
  assign w_as_ovf = signed_operation ? (w_sum[WIDTH] ^ w_sum[WIDTH-1]) : w_sum[WIDTH];

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_div   (mode[0]),
    .i_mag_a (w_mag_a),
    .i_mag_b (w_mag_b),
    .o_prod  (w_prod_mag),
    .o_quot  (w_quot_mag),
    .o_rem   (w_rem_mag),
    .o_fin   (w_fin)
  );

  assign w_prod     = f_neg_2w(w_prod_mag, r_neg_q);
  assign w_quot     = f_neg_w(w_quot_mag, r_neg_q);
  assign w_rem      = f_neg_w(w_rem_mag, r_neg_r);
  assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mul_ovf  = r_sgn ? !((&w_prod_top) || !(|w_prod_top))
                            : (|w_prod[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (r_state == DONE)
          w_next = IDLE;
        if (start)
          w_next = (!mode[1] || w_dbz) ? DONE : CALC;
      end
      CALC:    if (w_fin) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // Stage p0: staged result, written on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_div     <= mode[0];
      r_sgn     <= signed_operation;
      r_neg_q   <= w_neg_a ^ w_neg_b;
      r_neg_r   <= w_neg_a;
      r_min_ovf <= signed_operation && (mode == MODE_DIV) &&
                   (operand_a == MIN_VAL) && (operand_b == '1);
    end
    if (w_accept && !mode[1]) begin
      r_res_p0 <= w_as_res;
      r_vld_p0 <= 1'b1;
      r_ovf_p0 <= w_as_ovf;
      r_dbz_p0 <= 1'b0;
    end else if (w_accept && w_dbz) begin
      r_res_p0 <= '0;
      r_vld_p0 <= 1'b0;
      r_ovf_p0 <= 1'b0;
      r_dbz_p0 <= 1'b1;
    end else if (r_state == CALC && w_fin) begin
      r_res_p0 <= r_div ? {w_rem, w_quot} : w_prod;
      r_vld_p0 <= 1'b1;
      r_ovf_p0 <= r_div ? r_min_ovf : w_mul_ovf;
      r_dbz_p0 <= 1'b0;
    end
  end

  // Stage p1: visible outputs, updated once per DONE state with a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_dbz      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == DONE) begin
        r_result   <= r_res_p0;
        r_valid    <= r_vld_p0;
        r_overflow <= r_ovf_p0;
        r_dbz      <= r_dbz_p0;
      end
    end
  end

  assign busy           = (r_state == CALC);
  assign done           = r_done;
  assign result         = r_result;
  assign valid          = r_valid;
  assign overflow       = r_overflow;
  assign divide_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator (WIDTH=8): directed operations push
// hand-computed results; a monitor pops and checks on every done pulse.
module tb_seq_calculator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic        signed_operation;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        valid;
  logic        overflow;
  logic        divide_by_zero;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        v;
    logic        o;
    logic        z;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  seq_calculator #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .mode             (mode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .signed_operation (signed_operation),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .valid            (valid),
    .overflow         (overflow),
    .divide_by_zero   (divide_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_done: done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, {16'h0, result}, {16'h0, e.res});
        chk({e.name, "_valid"}, {31'h0, valid}, {31'h0, e.v});
        chk({e.name, "_overflow"}, {31'h0, overflow}, {31'h0, e.o});
        chk({e.name, "_dbz"}, {31'h0, divide_by_zero}, {31'h0, e.z});
        chk({e.name, "_done_cycle"}, cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input string nm, input logic [1:0] md, input logic [7:0] a,
                       input logic [7:0] b, input logic sg, input logic [15:0] er,
                       input logic ev, input logic eo, input logic ez, input int lat,
                       input bit push);
    int k;
    exp_t x;
    start = 1'b1;
    mode = md;
    operand_a = a;
    operand_b = b;
    signed_operation = sg;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    operand_a = ~a;
    operand_b = ~b;
    mode = ~md;
    signed_operation = ~sg;
    if (push) begin
      x.name = nm; x.res = er; x.v = ev; x.o = eo; x.z = ez; x.due = k + lat;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_result"}, {16'h0, result}, 32'h0);
    chk({nm, "_valid"}, {31'h0, valid}, 32'h0);
    chk({nm, "_overflow"}, {31'h0, overflow}, 32'h0);
    chk({nm, "_dbz"}, {31'h0, divide_by_zero}, 32'h0);
    chk({nm, "_busy"}, {31'h0, busy}, 32'h0);
    chk({nm, "_done"}, {31'h0, done}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int g;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'b00;
    operand_a = 8'h00;
    operand_b = 8'h00;
    signed_operation = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_quiet("reset_state");

    issue("uadd_05_03", 2'b00, 8'h05, 8'h03, 1'b0, 16'h0008, 1, 0, 0, 1, 1); drain();
    issue("usub_03_05", 2'b01, 8'h03, 8'h05, 1'b0, 16'h01FE, 1, 1, 0, 1, 1); drain();
    issue("uadd_FF_01", 2'b00, 8'hFF, 8'h01, 1'b0, 16'h0100, 1, 1, 0, 1, 1); drain();
    issue("ssub_FE_01", 2'b01, 8'hFE, 8'h01, 1'b1, 16'hFFFD, 1, 0, 0, 1, 1); drain();
    issue("ssub_80_01", 2'b01, 8'h80, 8'h01, 1'b1, 16'hFF7F, 1, 1, 0, 1, 1); drain();
    issue("sadd_7F_01", 2'b00, 8'h7F, 8'h01, 1'b1, 16'h0080, 1, 1, 0, 1, 1); drain();

    issue("umul_FF_FF", 2'b10, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 1, 0, 10, 1);
    nb = 0;
    g = 0;
    while (done !== 1'b1 && g < 30) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      g++;
    end
    chk("umul_busy_cycles", nb, 9);
    drain();

    issue("smul_FE_03", 2'b10, 8'hFE, 8'h03, 1'b1, 16'hFFFA, 1, 0, 0, 10, 1); drain();
    issue("udiv_64_07", 2'b11, 8'h64, 8'h07, 1'b0, 16'h020E, 1, 0, 0, 10, 1); drain();
    issue("sdiv_F9_02", 2'b11, 8'hF9, 8'h02, 1'b1, 16'hFFFD, 1, 0, 0, 10, 1); drain();
    issue("sdiv_80_FF", 2'b11, 8'h80, 8'hFF, 1'b1, 16'h0080, 1, 1, 0, 10, 1); drain();

    issue("div_by_zero", 2'b11, 8'h10, 8'h00, 1'b0, 16'h0000, 0, 0, 1, 1, 1);
    chk("dbz_busy", {31'h0, busy}, 32'h0);
    drain();

    // Back-to-back: second request lands in the DONE cycle of the first.
    issue("b2b_first", 2'b00, 8'h21, 8'h12, 1'b0, 16'h0033, 1, 0, 0, 1, 1);
    issue("b2b_second", 2'b01, 8'h10, 8'h20, 1'b1, 16'hFFF0, 1, 0, 0, 1, 1);
    drain();

    // start pulsed mid-multiply is ignored.
    issue("smul_ignore", 2'b10, 8'hFE, 8'h03, 1'b1, 16'hFFFA, 1, 0, 0, 10, 1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    mode = 2'b00;
    operand_a = 8'h01;
    operand_b = 8'h01;
    signed_operation = 1'b0;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);

    // Reset sampled at edge k+4 of a multiply aborts it.
    issue("mul_aborted", 2'b10, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 1, 0, 0, 10, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("mid_mul_reset");
    issue("add_after_reset", 2'b00, 8'h05, 8'h03, 1'b0, 16'h0008, 1, 0, 0, 1, 1);
    drain();
    repeat (14) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_calculator.md
# seq_calculator

Multi-cycle, width-parametrised arithmetic unit. It performs add, subtract, multiply and divide on WIDTH-bit operands, in signed or unsigned mode. Operands are latched on a start/busy/done handshake. Multiply and divide use an iterative shift-add / restoring datapath in place of single-cycle combinational logic. The block sits behind a controller or bus wrapper that issues one operation at a time and collects a registered 2·WIDTH-bit result with status flags.

## Interface
- WIDTH, 8, operand width in bits (≥ 4); result is 2·WIDTH bits
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- mode  in  2  00 add, 01 sub, 10 mul, 11 div
- operand_a  in  WIDTH  A / dividend
- operand_b  in  WIDTH  B / divisor
- signed_operation  in  1  0 unsigned, 1 two's-complement
- busy  out  1  high while iterating (CALC state)
- done  out  1  one-cycle pulse when outputs update
- result  out  2·WIDTH  registered result, held until next done
- valid  out  1  result meaningful (0 only on divide by zero)
- overflow  out  1  true result does not fit in WIDTH bits
- divide_by_zero  out  1  mode=11 with operand_b=0

## Operation
- FSM: IDLE → (accept, mode 00/01 or div-by-zero) → DONE; IDLE → (accept, mode 10/11) → CALC; CALC → (WIDTH iterations, then sign fix-up) → DONE; DONE → IDLE, or → accept again if start=1.
- Accept: start=1 in IDLE or DONE. mode, operands and signed_operation are latched, so later input changes are ignored. start in CALC is ignored, with no queueing.
- Add/sub: compute a (WIDTH+1)-bit exact result.
  - Signed: sign-extend to 2·WIDTH. overflow = result outside [−2^(W−1), 2^(W−1)−1].
  - Unsigned: zero-extend. overflow = bit W (carry on add, borrow on sub).
- Mul: shift-add on magnitudes, one bit per cycle, then negate if the operand signs differ. result = full 2·WIDTH product.
  - Unsigned: overflow = upper half ≠ 0.
  - Signed: overflow = product is not a sign extension of bit W−1.
- Div: restoring, on magnitudes, one quotient bit per cycle. result[W−1:0] = quotient, result[2W−1:W] = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed MIN/−1: quotient = MIN pattern, remainder 0, overflow=1.
- Divide by zero: no iteration. result=0, valid=0, overflow=0, divide_by_zero=1.
- Flags are updated together with result on the done edge, and held otherwise.

## Timing
- Accept at edge k.
- Add/sub/div-by-zero: result and flags updated at edge k+1, with done=1 during the cycle after.
- Mul/div: busy=1 from edge k to edge k+W+1. W iteration edges are followed by one fix-up edge. Outputs are updated and done=1 after edge k+W+2 (k+10 for W=8).
- done=1 for exactly one cycle. busy=0 in the DONE cycle, so back-to-back accept is allowed there.
- Reset (any cycle, including mid-CALC): state IDLE. busy, done, valid, overflow, divide_by_zero and result all go to 0. The aborted operation never produces done.
- start coincident with rst: rst wins and the request is dropped.

## Structure
- Shared package calc_pkg:
  - mode constants MODE_ADD/SUB/MUL/DIV
  - FSM state encoding IDLE/CALC/DONE
  - default WIDTH
- One sub-module, calc_iter_unit: magnitude shift-add / restoring-divide datapath with an iteration counter ($clog2(WIDTH)+1 bits). Sign handling and flags stay in the top level.

## Test plan
All scenarios use WIDTH=8.
- Unsigned add 05+03 → result 0008, valid=1, overflow=0, done one cycle after accept. Unsigned sub 03−05 → 01FE, overflow=1.
- Signed sub FE−01 → FFFD, overflow=0. Signed sub 80−01 → FF7F, overflow=1.
- Unsigned mul FF×FF → FE01, overflow=1, busy for 9 cycles, done at k+10. Signed mul FE×03 → FFFA, overflow=0.
- Unsigned div 64/07 → 020E. Signed div F9/02 → FFFD (q=FD, r=FF). Signed div 80/FF → 0080, overflow=1.
- Div by zero 10/00 → result 0000, valid=0, divide_by_zero=1, done at k+1, busy never set.
- Pulse start again mid-multiply → ignored, original result returned. Assert rst at k+4 of a multiply → all outputs 0 next cycle, no done; a new add accepted right after completes normally.
